// File: rtl/qos_pkg.sv
// qos_pkg: shared FSM state encoding and reset-value constants for the
// qos_router_n slice (qos_fifo and the router top both import this).
package qos_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_e;

    localparam state_e RST_STATE = S_RESET;
    localparam logic   RST_LO    = 1'b0;
    localparam logic   RST_HI    = 1'b1;

endpackage

// File: rtl/qos_fifo.sv
// qos_fifo: circular FIFO with an occupancy counter, threshold flags and a
// sticky error bit. A pop on empty or a rejected push raises the error; a push
// into a full FIFO is accepted only when PASS_WHEN_FULL is set and a pop
// happens on the same edge.
module qos_fifo
    import qos_pkg::*;
#(
    parameter int W              = 6,
    parameter int DEPTH          = 8,
    parameter int AW             = $clog2(DEPTH) + 1,
    parameter bit PASS_WHEN_FULL = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr_err,
    input  logic          i_push,
    input  logic [W-1:0]  i_din,
    input  logic          i_pop,
    input  logic [AW-1:0] i_high,
    input  logic [AW-1:0] i_low,
    output logic [W-1:0]  o_head,
    output logic [W-1:0]  o_dout,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_almost_full,
    output logic          o_almost_empty,
    output logic          o_err,
    output logic          o_err_evt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [AW-1:0] r_count;
    logic [W-1:0]  r_dout;
    logic          r_err;
    logic          w_pop_ok;
    logic          w_push_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign o_empty        = (r_count == {AW{1'b0}});
    assign o_full         = (r_count == AW'(DEPTH));
    assign w_pop_ok       = i_pop & ~o_empty;
    assign w_push_ok      = i_push & (~o_full | (PASS_WHEN_FULL & w_pop_ok));
    assign o_err_evt      = (i_pop & o_empty) | (i_push & ~w_push_ok);
    assign o_almost_full  = (r_count >= i_high);
    assign o_almost_empty = (r_count <= i_low);
    assign o_head         = r_mem[r_rd];
    assign o_dout         = r_dout;
    assign o_err          = r_err;

    // Storage write; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr] <= i_din;
        end
    end

    // Pointers, occupancy, registered read data and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= {PW{1'b0}};
            r_rd    <= {PW{1'b0}};
            r_count <= {AW{1'b0}};
            r_dout  <= {W{1'b0}};
            r_err   <= RST_LO;
        end else begin
            if (w_push_ok) begin
                r_wr <= ptr_inc(r_wr);
            end
            if (w_pop_ok) begin
                r_rd   <= ptr_inc(r_rd);
                r_dout <= r_mem[r_rd];
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + AW'(1);
                2'b01:   r_count <= r_count - AW'(1);
                default: r_count <= r_count;
            endcase
            if (i_clr_err) begin
                r_err <= RST_LO;
            end else if (o_err_evt) begin
                r_err <= RST_HI;
            end
        end
    end

endmodule

// File: rtl/qos_router_n.sv
// qos_router_n: input FIFO feeding N_DEST output channel FIFOs selected by the
// top DEST_BITS of each word, with in-order head-of-line blocking on the
// latched almost-full threshold. Optional per-channel transfer counters are
// enabled by defining QOS_ROUTER_STATS_EN.
module qos_router_n
    import qos_pkg::*;
#(
    parameter int BW         = 6,
    parameter int DEST_BITS  = 1,
    parameter int DEPTH      = 8,
    parameter int MAIN_DEPTH = 4,
    parameter int AW         = $clog2(DEPTH) + 1,
    localparam int N_DEST    = 2 ** DEST_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 main_wr,
    input  logic [BW-1:0]        main_data_in,
    output logic                 main_full,
    input  logic [N_DEST*AW-1:0] umbral_high,
    input  logic [N_DEST*AW-1:0] umbral_low,
    input  logic [N_DEST-1:0]    d_rd,
    output logic [N_DEST*BW-1:0] d_data_out,
    output logic [N_DEST-1:0]    d_empty,
    output logic [N_DEST-1:0]    d_almost_full,
    output logic [N_DEST-1:0]    d_almost_empty,
    output logic [N_DEST:0]      error_full,
    output logic                 error_out,
    output logic                 idle_out,
    output logic                 active_out
`ifdef QOS_ROUTER_STATS_EN
    ,output logic [N_DEST*16-1:0] d_count
`endif
);

    localparam int MAW = $clog2(MAIN_DEPTH) + 1;

    state_e                 r_state;
    state_e                 w_next;
    logic                   r_idle;
    logic                   r_active;
    logic                   r_error;
    logic [N_DEST*AW-1:0]   r_high;
    logic [N_DEST*AW-1:0]   r_low;

    logic [BW-1:0]          w_main_head;
    logic [BW-1:0]          w_main_dout;
    logic                   w_main_empty;
    logic                   w_main_full;
    logic                   w_main_af;
    logic                   w_main_ae;
    logic                   w_main_err;
    logic                   w_main_err_evt;
    logic                   w_main_push;
    logic                   w_run;
    logic                   w_xfer;
    logic                   w_err_evt;
    logic                   w_any;
    logic                   w_enter_init;
    logic [DEST_BITS-1:0]   w_dest;

    logic [N_DEST*BW-1:0]   w_ch_head;
    logic [N_DEST-1:0]      w_ch_empty;
    logic [N_DEST-1:0]      w_ch_full;
    logic [N_DEST-1:0]      w_ch_af;
    logic [N_DEST-1:0]      w_ch_ae;
    logic [N_DEST-1:0]      w_ch_err;
    logic [N_DEST-1:0]      w_ch_err_evt;
    logic [N_DEST-1:0]      w_ch_push;
    logic                   w_unused_bits;

    assign w_run        = (r_state == S_IDLE) || (r_state == S_ACTIVE);
    assign w_main_push  = w_run & main_wr;
    assign w_dest       = w_main_head[BW-1 -: DEST_BITS];
    // A full channel only accepts the head word when it is popped on the same edge.
    assign w_xfer       = w_run & ~w_main_empty & ~w_ch_af[w_dest]
                          & (~w_ch_full[w_dest] | d_rd[w_dest]);
    assign w_err_evt    = w_main_err_evt | (|w_ch_err_evt);
    assign w_any        = ~w_main_empty | ~(&w_ch_empty);
    assign w_enter_init = (w_next == S_INIT) && (r_state != S_INIT);

    qos_fifo #(
        .W(BW), .DEPTH(MAIN_DEPTH), .AW(MAW), .PASS_WHEN_FULL(1'b0)
    ) u_main_fifo (
        .clk            (clk),
        .reset          (reset),
        .i_clr_err      (w_enter_init),
        .i_push         (w_main_push),
        .i_din          (main_data_in),
        .i_pop          (w_xfer),
        .i_high         (MAW'(MAIN_DEPTH)),
        .i_low          ({MAW{1'b0}}),
        .o_head         (w_main_head),
        .o_dout         (w_main_dout),
        .o_empty        (w_main_empty),
        .o_full         (w_main_full),
        .o_almost_full  (w_main_af),
        .o_almost_empty (w_main_ae),
        .o_err          (w_main_err),
        .o_err_evt      (w_main_err_evt)
    );

    for (genvar k = 0; k < N_DEST; k++) begin : g_ch
        assign w_ch_push[k] = w_xfer & (w_dest == DEST_BITS'(k));

        qos_fifo #(
            .W(BW), .DEPTH(DEPTH), .AW(AW), .PASS_WHEN_FULL(1'b1)
        ) u_ch_fifo (
            .clk            (clk),
            .reset          (reset),
            .i_clr_err      (w_enter_init),
            .i_push         (w_ch_push[k]),
            .i_din          (w_main_head),
            .i_pop          (d_rd[k]),
            .i_high         (r_high[k*AW +: AW]),
            .i_low          (r_low[k*AW +: AW]),
            .o_head         (w_ch_head[k*BW +: BW]),
            .o_dout         (d_data_out[k*BW +: BW]),
            .o_empty        (w_ch_empty[k]),
            .o_full         (w_ch_full[k]),
            .o_almost_full  (w_ch_af[k]),
            .o_almost_empty (w_ch_ae[k]),
            .o_err          (w_ch_err[k]),
            .o_err_evt      (w_ch_err_evt[k])
        );
    end

    assign w_unused_bits  = ^{w_main_dout, w_main_af, w_main_ae, w_ch_head};
    assign main_full      = w_main_full;
    assign d_empty        = w_ch_empty;
    assign d_almost_empty = w_ch_ae;
    // Thresholds are zero in RESET, so the raw compare is masked there.
    assign d_almost_full  = w_ch_af & {N_DEST{r_state != S_RESET}};
    assign error_full     = {w_ch_err, w_main_err};
    assign error_out      = r_error;
    assign idle_out       = r_idle;
    assign active_out     = r_active;

    // Next-state selection; an error event outranks an init request.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET: w_next = S_INIT;
            S_INIT: begin
                if (init) begin
                    w_next = S_INIT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_IDLE, S_ACTIVE: begin
                if (w_err_evt) begin
                    w_next = S_ERROR;
                end else if (init) begin
                    w_next = S_INIT;
                end else if (w_any) begin
                    w_next = S_ACTIVE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ERROR: begin
                if (init) begin
                    w_next = S_INIT;
                end else begin
                    w_next = S_ERROR;
                end
            end
            default: w_next = S_RESET;
        endcase
    end

    // State register with registered state-decode outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= RST_STATE;
            r_idle   <= RST_LO;
            r_active <= RST_LO;
            r_error  <= RST_LO;
        end else begin
            r_state  <= w_next;
            r_idle   <= (w_next == S_IDLE);
            r_active <= (w_next == S_ACTIVE);
            r_error  <= (w_next == S_ERROR);
        end
    end

    // Threshold copies follow the inputs on every INIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_high <= {(N_DEST*AW){1'b0}};
            r_low  <= {(N_DEST*AW){1'b0}};
        end else if (r_state == S_INIT) begin
            r_high <= umbral_high;
            r_low  <= umbral_low;
        end
    end

`ifdef QOS_ROUTER_STATS_EN
    logic [15:0] r_cnt [N_DEST];

    for (genvar k = 0; k < N_DEST; k++) begin : g_cnt
        assign d_count[k*16 +: 16] = r_cnt[k];

        // Per-channel transfer counter, wrapping at 2**16.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt[k] <= 16'd0;
            end else if (w_enter_init) begin
                r_cnt[k] <= 16'd0;
            end else if (w_ch_push[k]) begin
                r_cnt[k] <= r_cnt[k] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_qos_router_n.sv
// tb_qos_router_n: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based reference model of the router.
module tb_qos_router_n;

    localparam int DEPTH = 8;
    localparam int MD    = 4;
    localparam int ST_RESET = 0, ST_INIT = 1, ST_IDLE = 2, ST_ACTIVE = 3, ST_ERROR = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic        main_wr;
    logic [5:0]  main_data_in;
    logic        main_full;
    logic [7:0]  umbral_high;
    logic [7:0]  umbral_low;
    logic [1:0]  d_rd;
    logic [11:0] d_data_out;
    logic [1:0]  d_empty;
    logic [1:0]  d_almost_full;
    logic [1:0]  d_almost_empty;
    logic [2:0]  error_full;
    logic        error_out;
    logic        idle_out;
    logic        active_out;

    qos_router_n dut (
        .clk            (clk),
        .reset          (reset),
        .init           (init),
        .main_wr        (main_wr),
        .main_data_in   (main_data_in),
        .main_full      (main_full),
        .umbral_high    (umbral_high),
        .umbral_low     (umbral_low),
        .d_rd           (d_rd),
        .d_data_out     (d_data_out),
        .d_empty        (d_empty),
        .d_almost_full  (d_almost_full),
        .d_almost_empty (d_almost_empty),
        .error_full     (error_full),
        .error_out      (error_out),
        .idle_out       (idle_out),
        .active_out     (active_out)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int         m_st;
    logic [5:0] mq[$];
    logic [5:0] cq[2][$];
    logic [3:0] m_hi[2];
    logic [3:0] m_lo[2];
    logic [2:0] m_err;
    logic [5:0] m_dout[2];

    // Model update on each rising edge, then compare all outputs.
    always @(posedge clk) begin : model
        logic [2:0] new_err;
        logic [1:0] pop_ok;
        logic [5:0] w;
        bit         evt, run, xfer, acc, any;
        int         dst, occ, nxt;
        if (reset) begin
            m_st = ST_RESET;
            mq.delete();
            for (int k = 0; k < 2; k++) begin
                cq[k].delete();
                m_hi[k] = 4'd0;
                m_lo[k] = 4'd0;
                m_dout[k] = 6'd0;
            end
            m_err = 3'd0;
        end else begin
            run = (m_st == ST_IDLE) || (m_st == ST_ACTIVE);
            evt = 1'b0;
            new_err = 3'd0;
            for (int k = 0; k < 2; k++) begin
                pop_ok[k] = d_rd[k] && (cq[k].size() > 0);
                if (d_rd[k] && cq[k].size() == 0) begin
                    new_err[k+1] = 1'b1;
                    evt = 1'b1;
                end
            end
            xfer = 1'b0;
            dst = 0;
            if (run && mq.size() > 0) begin
                dst = int'(mq[0][5]);
                occ = cq[dst].size();
                if (!(occ >= int'(m_hi[dst])) && (occ < DEPTH || d_rd[dst])) xfer = 1'b1;
            end
            acc = 1'b0;
            if (run && main_wr) begin
                if (mq.size() == MD) begin
                    new_err[0] = 1'b1;
                    evt = 1'b1;
                end else begin
                    acc = 1'b1;
                end
            end
            any = (mq.size() > 0) || (cq[0].size() > 0) || (cq[1].size() > 0);
            case (m_st)
                ST_RESET: nxt = ST_INIT;
                ST_INIT:  nxt = init ? ST_INIT : ST_IDLE;
                ST_IDLE, ST_ACTIVE:
                    nxt = evt ? ST_ERROR : (init ? ST_INIT : (any ? ST_ACTIVE : ST_IDLE));
                default:  nxt = init ? ST_INIT : ST_ERROR;
            endcase
            for (int k = 0; k < 2; k++) if (pop_ok[k]) m_dout[k] = cq[k].pop_front();
            if (xfer) begin
                w = mq.pop_front();
                cq[dst].push_back(w);
            end
            if (acc) mq.push_back(main_data_in);
            if (m_st == ST_INIT) begin
                for (int k = 0; k < 2; k++) begin
                    m_hi[k] = umbral_high[k*4 +: 4];
                    m_lo[k] = umbral_low[k*4 +: 4];
                end
            end
            if (nxt == ST_INIT && m_st != ST_INIT) m_err = 3'd0;
            else m_err = m_err | new_err;
            m_st = nxt;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("m_empty%0d", k), d_empty[k], cq[k].size() == 0);
            check($sformatf("m_afull%0d", k), d_almost_full[k],
                  (m_st != ST_RESET) && (cq[k].size() >= int'(m_hi[k])));
            check($sformatf("m_aempty%0d", k), d_almost_empty[k], cq[k].size() <= int'(m_lo[k]));
            check($sformatf("m_dout%0d", k), d_data_out[k*6 +: 6], m_dout[k]);
        end
        check("m_main_full", main_full, mq.size() == MD);
        check("m_error_full", error_full, m_err);
        check("m_error_out", error_out, m_st == ST_ERROR);
        check("m_idle_out", idle_out, m_st == ST_IDLE);
        check("m_active_out", active_out, m_st == ST_ACTIVE);
    end

    task automatic push(input logic [5:0] w);
        main_wr = 1'b1;
        main_data_in = w;
        @(negedge clk);
        main_wr = 1'b0;
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_d_empty"}, d_empty, 2'b11);
        check({tag, "_main_full"}, main_full, 1'b0);
        check({tag, "_afull"}, d_almost_full, 2'b00);
        check({tag, "_aempty"}, d_almost_empty, 2'b11);
        check({tag, "_errfull"}, error_full, 3'b000);
        check({tag, "_flags"}, {error_out, idle_out, active_out}, 3'b000);
        check({tag, "_dout"}, d_data_out, 12'h000);
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; main_wr = 1'b0; main_data_in = 6'd0; d_rd = 2'b00;
        umbral_high = {4'd3, 4'd3};
        umbral_low  = {4'd1, 4'd1};
        repeat (2) @(negedge clk);
        reset_values("rst");
        reset = 1'b0;
        @(negedge clk);
        check("in_init_flags", {error_out, idle_out, active_out}, 3'b000);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        @(negedge clk);
        check("idle_before_push", idle_out, 1'b1);

        // first word: lands in channel 0 one edge after the push
        push(6'b000001);
        check("empty_at_push_edge", d_empty, 2'b11);
        @(negedge clk);
        check("active_after_push", active_out, 1'b1);
        check("d_empty0_cleared", d_empty, 2'b10);
        d_rd = 2'b01;
        @(negedge clk);
        d_rd = 2'b00;
        check("first_readback", d_data_out[5:0], 6'b000001);

        // routing by the top bit
        push(6'b011111);
        push(6'b001100);
        push(6'b100101);
        repeat (3) @(negedge clk);
        check("route_empty", d_empty, 2'b00);
        check("route_afull", d_almost_full, 2'b00);
        d_rd = 2'b01;
        @(negedge clk);
        check("route_rd0a", d_data_out[5:0], 6'b011111);
        @(negedge clk);
        check("route_rd0b", d_data_out[5:0], 6'b001100);
        d_rd = 2'b10;
        @(negedge clk);
        d_rd = 2'b00;
        check("route_rd1", d_data_out, {6'b100101, 6'b001100});
        check("route_no_err", error_full, 3'b000);

        // head-of-line stall and input overflow
        for (int i = 1; i <= 7; i++) push(6'(i));
        check("stall_afull", d_almost_full, 2'b01);
        check("stall_main_full", main_full, 1'b1);
        check("stall_no_err", error_full, 3'b000);
        push(6'd8);
        check("ovf_err0", error_full, 3'b001);
        check("ovf_error_out", error_out, 1'b1);

        // read of an empty channel, then init clears the errors
        d_rd = 2'b10;
        @(negedge clk);
        d_rd = 2'b00;
        check("rd_empty_err", error_full, 3'b101);
        umbral_high = {4'd3, 4'd9};
        init = 1'b1;
        @(negedge clk);
        check("init_clears_err", error_full, 3'b000);
        check("init_flags", {error_out, idle_out, active_out}, 3'b000);
        init = 1'b0;
        repeat (7) @(negedge clk);
        check("drain_main", main_full, 1'b0);

        // channel 0 full, pop and transfer on the same edge
        push(6'd9);
        @(negedge clk);
        check("full_no_afull", d_almost_full, 2'b00);
        push(6'd10);
        @(negedge clk);
        d_rd = 2'b01;
        @(negedge clk);
        check("full_pass_dout", d_data_out[5:0], 6'd1);
        check("full_pass_noerr", error_full, 3'b000);
        for (int i = 0; i < 8; i++) @(negedge clk);
        d_rd = 2'b00;
        check("full_pass_last", d_data_out[5:0], 6'd10);
        check("full_pass_empty", d_empty, 2'b11);
        check("full_pass_noerr2", error_full, 3'b000);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            main_wr = ($urandom_range(0, 2) != 0);
            main_data_in = 6'($urandom);
            d_rd = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            if ($urandom_range(0, 60) == 0) begin
                init = 1'b1;
                umbral_high = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
                umbral_low  = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end else begin
                init = 1'b0;
            end
            @(negedge clk);
        end
        main_wr = 1'b0; d_rd = 2'b00; init = 1'b1;
        umbral_high = {4'd3, 4'd3};
        @(negedge clk);
        init = 1'b0;
        @(negedge clk);

        // asynchronous reset while traffic is moving
        main_wr = 1'b1; main_data_in = 6'b100011;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 reset_values("async");
        main_wr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_init_flags", {error_out, idle_out, active_out}, 3'b000);
        check("post_rst_init_afull", d_almost_full, 2'b11);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_idle", idle_out, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
